mpmp_fifo_ctl: RTL and testbench

//   Multi-push / multi-pop FIFO with lane-count handshake. Up to NI words are written and up to
//   NO words are read per clock. Adds depth not restricted to a power of two, an occupancy

---
 rtl/mpmp_fifo_ctl_if.sv | 36 +++
 rtl/mpmp_fifo_ctl.sv | 133 +++++++++++++
 tb/tb_mpmp_fifo_ctl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mpmp_fifo_ctl_if.sv
// Handshake bundle for the multi-push / multi-pop FIFO controller.
// The FIFO uses the slave modport. Producer and consumer logic use the master modport.
interface mpmp_fifo_ctl_if #(
  parameter int W  = 8,
  parameter int D  = 8,
  parameter int NI = 4,
  parameter int NO = 4
);
  localparam int WI = $clog2(NI + 1);
  localparam int WO = $clog2(NO + 1);
  localparam int WC = $clog2(D + 1);

  logic [WI-1:0]         push;
  logic [NI-1:0][W-1:0]  push_data;
  logic [WO-1:0]         pop;
  logic [NO-1:0][W-1:0]  pop_data;
  logic [WI-1:0]         can_push;
  logic [WO-1:0]         can_pop;
  logic [WC-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  flush;
  logic                  err_clr;
  logic                  ovf;
  logic                  udf;

  modport slave (
    input  push, push_data, pop, flush, err_clr,
    output pop_data, can_push, can_pop, count, almost_full, almost_empty, ovf, udf
  );

  modport master (
    output push, push_data, pop, flush, err_clr,
    input  pop_data, can_push, can_pop, count, almost_full, almost_empty, ovf, udf
  );
endinterface

// File: rtl/mpmp_fifo_ctl.sv
// Multi-push / multi-pop FIFO controller with lane-count handshake.
// The depth does not need to be a power of two. All outputs come from registers.
// Each output register is loaded from the next-state view of the FIFO, including
// the next memory image. This lets a word pushed in one cycle appear on pop_data
// in the next cycle.
module mpmp_fifo_ctl #(
  parameter int W      = 8,
  parameter int D      = 8,
  parameter int NI     = 4,
  parameter int NO     = 4,
  parameter int AF_LVL = D - 1,
  parameter int AE_LVL = 1
) (
  input  logic               clk,
  input  logic               rstn,
  mpmp_fifo_ctl_if.slave     bus
);
  localparam int WI  = $clog2(NI + 1);
  localparam int WO  = $clog2(NO + 1);
  localparam int WC  = $clog2(D + 1);
  localparam int WP  = (D > 1) ? $clog2(D) : 1;
  localparam int WS  = WC + 1;
  localparam int CP0 = (NI < D) ? NI : D;

  // Pointer advance modulo D. The increment is at most D, so one conditional
  // subtraction is enough.
  function automatic logic [WP-1:0] wrap_add(input logic [WP-1:0] p, input logic [WC-1:0] inc);
    logic [WS-1:0] s;
    s = WS'(p) + WS'(inc);
    s = (s >= WS'(D)) ? (s - WS'(D)) : s;
    return s[WP-1:0];
  endfunction

  logic [W-1:0]          mem_q [D];
  logic [W-1:0]          mem_d [D];
  logic [WP-1:0]         wr_ptr_q, wr_ptr_d;
  logic [WP-1:0]         rd_ptr_q, rd_ptr_d;
  logic [WC-1:0]         count_q, count_d;
  logic [WI-1:0]         can_push_q, can_push_d;
  logic [WO-1:0]         can_pop_q, can_pop_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [NO-1:0][W-1:0]  pop_data_q, pop_data_d;

  logic [WI-1:0]         pa_s;
  logic [WO-1:0]         qa_s;
  logic                  push_err_s;
  logic                  pop_err_s;
  logic [WC-1:0]         room_s;

  // Next-state computation: accepted lane counts, errors, pointers, memory image, output values.
  always_comb begin
    push_err_s = (bus.push > can_push_q);
    pop_err_s  = (bus.pop > can_pop_q);
    pa_s       = push_err_s ? can_push_q : bus.push;
    qa_s       = pop_err_s ? can_pop_q : bus.pop;

    // A flush swallows same-cycle traffic, so that traffic cannot raise an error.
    // A new error outranks err_clr.
    ovf_d = (!bus.flush && push_err_s) ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    udf_d = (!bus.flush && pop_err_s)  ? 1'b1 : (bus.err_clr ? 1'b0 : udf_q);

    mem_d = mem_q;
    for (int i = 0; i < NI; i++) begin
      mem_d[wrap_add(wr_ptr_q, WC'(i))] = (!bus.flush && (i < 32'(pa_s)))
                                          ? bus.push_data[i]
                                          : mem_d[wrap_add(wr_ptr_q, WC'(i))];
    end

    if (bus.flush) begin
      wr_ptr_d = {WP{1'b0}};
      rd_ptr_d = {WP{1'b0}};
      count_d  = {WC{1'b0}};
    end else begin
      wr_ptr_d = wrap_add(wr_ptr_q, WC'(pa_s));
      rd_ptr_d = wrap_add(rd_ptr_q, WC'(qa_s));
      count_d  = count_q + WC'(pa_s) - WC'(qa_s);
    end

    room_s     = WC'(D) - count_d;
    can_push_d = (room_s > WC'(NI)) ? WI'(NI) : WI'(room_s);
    can_pop_d  = (count_d > WC'(NO)) ? WO'(NO) : WO'(count_d);
    af_d       = (32'(count_d) >= AF_LVL);
    ae_d       = (32'(count_d) <= AE_LVL);

    for (int i = 0; i < NO; i++) begin
      pop_data_d[i] = (i < 32'(can_pop_d)) ? mem_d[wrap_add(rd_ptr_d, WC'(i))] : {W{1'b0}};
    end
  end

  // Storage array. Contents are never reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= {WP{1'b0}};
      rd_ptr_q   <= {WP{1'b0}};
      count_q    <= {WC{1'b0}};
      can_push_q <= WI'(CP0);
      can_pop_q  <= {WO{1'b0}};
      af_q       <= (AF_LVL == 0) ? 1'b1 : 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      pop_data_q <= {(NO*W){1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      can_push_q <= can_push_d;
      can_pop_q  <= can_pop_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      pop_data_q <= pop_data_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.can_push     = can_push_q;
  assign bus.can_pop      = can_pop_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
  assign bus.pop_data     = pop_data_q;
endmodule

// File: tb/tb_mpmp_fifo_ctl.sv
// Testbench for mpmp_fifo_ctl, built as W=8, D=6, NI=4, NO=3, AF_LVL=5, AE_LVL=1.
// The reference model is a plain queue of words plus two sticky error bits.
module tb_mpmp_fifo_ctl;
  localparam int W = 8, D = 6, NI = 4, NO = 3, AF = 5, AE = 1;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  logic [7:0] q [$];
  bit         m_ovf;
  bit         m_udf;

  mpmp_fifo_ctl_if #(.W(W), .D(D), .NI(NI), .NO(NO)) bus ();

  mpmp_fifo_ctl #(.W(W), .D(D), .NI(NI), .NO(NO), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the values the queue model implies.
  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".count"},    32'(bus.count),        32'(sz));
    chk({tag, ".can_push"}, 32'(bus.can_push),     32'(imin(NI, D - sz)));
    chk({tag, ".can_pop"},  32'(bus.can_pop),      32'(imin(NO, sz)));
    chk({tag, ".af"},       32'(bus.almost_full),  32'(sz >= AF));
    chk({tag, ".ae"},       32'(bus.almost_empty), 32'(sz <= AE));
    chk({tag, ".ovf"},      32'(bus.ovf),          32'(m_ovf));
    chk({tag, ".udf"},      32'(bus.udf),          32'(m_udf));
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("%s.pop_data%0d", tag, i), 32'(bus.pop_data[i]),
          (i < imin(NO, sz)) ? 32'(q[i]) : 32'd0);
    end
  endtask

  // Run one clock of traffic, update the model, then check at the falling edge.
  task automatic step(input string tag, input int p, input logic [31:0] data,
                      input int pp, input bit fl, input bit ec);
    int sz, cp, cq, pa, qa;
    bus.push      = 3'(p);
    bus.push_data = data;
    bus.pop       = 2'(pp);
    bus.flush     = fl;
    bus.err_clr   = ec;
    @(posedge clk);
    sz = q.size();
    cp = imin(NI, D - sz);
    cq = imin(NO, sz);
    if (ec) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (p > cp) m_ovf = 1'b1;
      if (pp > cq) m_udf = 1'b1;
      pa = imin(p, cp);
      qa = imin(pp, cq);
      for (int i = 0; i < qa; i++) void'(q.pop_front());
      for (int i = 0; i < pa; i++) q.push_back(data[8*i +: 8]);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.push      = 3'd0;
    bus.push_data = 32'd0;
    bus.pop       = 2'd0;
    bus.flush     = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    rstn   = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // 1: state right after reset
    check_all("reset");
    chk("reset.can_push_const", 32'(bus.can_push), 32'd4);
    chk("reset.ae_const", 32'(bus.almost_empty), 32'd1);

    // 2: push three words, then pop one
    step("t2_push", 3, 32'h00030201, 0, 1'b0, 1'b0);
    chk("t2.lane0", 32'(bus.pop_data[0]), 32'd1);
    chk("t2.lane2", 32'(bus.pop_data[2]), 32'd3);
    step("t2_pop", 0, 32'd0, 1, 1'b0, 1'b0);
    chk("t2.pop_lane2_zero", 32'(bus.pop_data[2]), 32'd0);
    step("t2_drain", 0, 32'd0, 2, 1'b0, 1'b0);

    // 3: pointer wrap with the non-power-of-two depth
    step("t3_a", 4, 32'h04030201, 0, 1'b0, 1'b0);
    step("t3_b", 2, 32'h00000605, 0, 1'b0, 1'b0);
    step("t3_c", 0, 32'd0, 3, 1'b0, 1'b0);
    chk("t3.head4", 32'(bus.pop_data[0]), 32'd4);
    step("t3_d", 3, 32'h00090807, 0, 1'b0, 1'b0);
    step("t3_e", 0, 32'd0, 3, 1'b0, 1'b0);
    chk("t3.head7", 32'(bus.pop_data[0]), 32'd7);
    step("t3_f", 0, 32'd0, 3, 1'b0, 1'b0);
    chk("t3.empty", 32'(bus.count), 32'd0);

    // 4: overflow at count 5, then clear it
    step("t4_a", 4, 32'h14131211, 0, 1'b0, 1'b0);
    step("t4_b", 1, 32'h00000015, 0, 1'b0, 1'b0);
    step("t4_ovf", 4, 32'hDDCCBBAA, 0, 1'b0, 1'b0);
    chk("t4.ovf_const", 32'(bus.ovf), 32'd1);
    chk("t4.can_push_zero", 32'(bus.can_push), 32'd0);
    step("t4_clr", 0, 32'd0, 0, 1'b0, 1'b1);

    // 5: simultaneous push and pop, then underflow
    step("t5_a", 0, 32'd0, 2, 1'b0, 1'b0);
    step("t5_b", 2, 32'h00002221, 3, 1'b0, 1'b0);
    chk("t5.count3", 32'(bus.count), 32'd3);
    step("t5_c", 0, 32'd0, 1, 1'b0, 1'b0);
    step("t5_udf", 0, 32'd0, 3, 1'b0, 1'b0);
    chk("t5.udf_const", 32'(bus.udf), 32'd1);
    step("t5_clr_setwins", 0, 32'd0, 1, 1'b0, 1'b1);

    // 6: flush while ovf is set, with a push in the same cycle
    step("t6_a", 4, 32'h34333231, 0, 1'b0, 1'b1);
    step("t6_ovf", 4, 32'h38373635, 0, 1'b0, 1'b0);
    step("t6_flush", 4, 32'h44434241, 3, 1'b1, 1'b0);
    chk("t6.ovf_kept", 32'(bus.ovf), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step("rnd", $urandom_range(0, NI), $urandom, $urandom_range(0, NO),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset in the middle of a cycle, with traffic still driven
    step("pre_rst", 4, 32'h55545352, 1, 1'b0, 1'b0);
    bus.push = 3'd4;
    bus.pop  = 2'd3;
    #2 rstn = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all("rst_mid");
    idle_inputs();
    @(negedge clk);
    check_all("rst_hold");
    rstn = 1'b1;
    for (int n = 0; n < 150; n++) begin
      step("rnd2", $urandom_range(0, NI), $urandom, $urandom_range(0, NO),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
